// File: rtl/stage_4.sv
// stage_4: final adder of the chain; multi-cycle IEEE-754 single-precision add
// with fixed latency (start edge + 5 enabled edges) and a one-cycle done pulse.
module stage_4 #(
   parameter int unsigned FLOAT_DATA_WIDTH = 32,
   parameter int unsigned EXP_WIDTH        = 8,
   parameter int unsigned MANT_WIDTH       = 23
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clk_en,
   input  logic                        start,
   input  logic [FLOAT_DATA_WIDTH-1:0] to_add_one,
   input  logic [FLOAT_DATA_WIDTH-1:0] to_add_two,
   output logic [FLOAT_DATA_WIDTH-1:0] result,
   output logic                        done,
   output logic                        working
);
   localparam int unsigned SIG_W = MANT_WIDTH + 1;
   localparam int unsigned FLD_W = SIG_W + 3;
   localparam int unsigned SUM_W = FLD_W + 1;
   localparam int unsigned XE_W  = EXP_WIDTH + 2;
   localparam int unsigned LZ_W  = 5;
   localparam logic [EXP_WIDTH-1:0]        EXP_MAX = '1;
   localparam logic [EXP_WIDTH-1:0]        SH_MAX  = EXP_WIDTH'(FLD_W - 1);
   localparam logic [FLOAT_DATA_WIDTH-1:0] QNAN    = FLOAT_DATA_WIDTH'(32'h7FC0_0000);

   typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_PACK} state_t;

   state_t                        r_state;
   logic [FLOAT_DATA_WIDTH-1:0]   r_a, r_b;
   logic                          r_sl, r_ss;
   logic [EXP_WIDTH-1:0]          r_el, r_es;
   logic [SIG_W-1:0]              r_ml, r_ms;
   logic [FLD_W-1:0]              r_fl, r_fs, r_norm;
   logic [SUM_W-1:0]              r_sum;
   logic [XE_W-1:0]               r_exp;
   logic                          r_nan, r_inf, r_inf_sign, r_zero;

   logic                          w_sa, w_sb, w_a_ge_b;
   logic [EXP_WIDTH-1:0]          w_ea, w_eb, w_diff;
   logic [MANT_WIDTH-1:0]         w_fra, w_frb, w_frac;
   logic [SIG_W-1:0]              w_ma, w_mb;
   logic                          w_nan_a, w_nan_b, w_inf_a, w_inf_b;
   logic [FLD_W-1:0]              w_fs_raw, w_fs_shift, w_fs, w_norm;
   logic [SUM_W-1:0]              w_sum;
   logic [LZ_W-1:0]               w_lz;
   logic                          w_found;
   logic [XE_W-1:0]               w_nexp, w_pexp;
   logic [SIG_W:0]                w_m25;
   logic                          w_rup;
   logic [FLOAT_DATA_WIDTH-1:0]   w_res;

   // Unpack and classify the captured operands, flushing denormals to zero.
   always_comb begin
      w_sa     = r_a[FLOAT_DATA_WIDTH-1];
      w_sb     = r_b[FLOAT_DATA_WIDTH-1];
      w_ea     = r_a[FLOAT_DATA_WIDTH-2 -: EXP_WIDTH];
      w_eb     = r_b[FLOAT_DATA_WIDTH-2 -: EXP_WIDTH];
      w_fra    = r_a[MANT_WIDTH-1:0];
      w_frb    = r_b[MANT_WIDTH-1:0];
      w_ma     = (w_ea == '0) ? '0 : {1'b1, w_fra};
      w_mb     = (w_eb == '0) ? '0 : {1'b1, w_frb};
      w_nan_a  = (w_ea == EXP_MAX) && (w_fra != '0);
      w_nan_b  = (w_eb == EXP_MAX) && (w_frb != '0);
      w_inf_a  = (w_ea == EXP_MAX) && (w_fra == '0);
      w_inf_b  = (w_eb == EXP_MAX) && (w_frb == '0);
      w_a_ge_b = {w_ea, w_ma} >= {w_eb, w_mb};
   end

   // Align: right shift the smaller significand, collapsing lost bits into sticky.
   always_comb begin
      w_diff     = r_el - r_es;
      w_fs_raw   = {r_ms, 3'b000};
      w_fs_shift = w_fs_raw >> w_diff;
      if (w_diff >= SH_MAX)
         w_fs = {{(FLD_W-1){1'b0}}, |r_ms};
      else
         w_fs = {w_fs_shift[FLD_W-1:1],
                 w_fs_shift[0] | (|(w_fs_raw & ~({FLD_W{1'b1}} << w_diff)))};
   end

   always_comb begin
      if (r_sl == r_ss) w_sum = {1'b0, r_fl} + {1'b0, r_fs};
      else              w_sum = {1'b0, r_fl} - {1'b0, r_fs};
   end

   // Normalise: carry-out right shift, else leading-zero count and left shift.
   always_comb begin
      w_lz    = '0;
      w_found = 1'b0;
      for (int i = int'(FLD_W) - 1; i >= 0; i--) begin
         if (!w_found && r_sum[i]) begin
            w_lz    = LZ_W'(int'(FLD_W) - 1 - i);
            w_found = 1'b1;
         end
      end
      if (r_sum[SUM_W-1]) begin
         w_norm = {r_sum[SUM_W-1:2], r_sum[1] | r_sum[0]};
         w_nexp = r_exp + XE_W'(1);
      end else begin
         w_norm = r_sum[FLD_W-1:0] << w_lz;
         w_nexp = r_exp - {{(XE_W-LZ_W){1'b0}}, w_lz};
      end
   end

   // Round to nearest even, then resolve special cases into the packed result.
   always_comb begin
      w_rup = r_norm[2] & (r_norm[1] | r_norm[0] | r_norm[3]);
      w_m25 = {1'b0, r_norm[FLD_W-1:3]} + {{SIG_W{1'b0}}, w_rup};
      if (w_m25[SIG_W]) begin
         w_frac = w_m25[MANT_WIDTH:1];
         w_pexp = r_exp + XE_W'(1);
      end else begin
         w_frac = w_m25[MANT_WIDTH-1:0];
         w_pexp = r_exp;
      end
      if (r_nan)
         w_res = QNAN;
      else if (r_inf)
         w_res = {r_inf_sign, EXP_MAX, {MANT_WIDTH{1'b0}}};
      else if (r_zero)
         w_res = {r_sl & r_ss, {(FLOAT_DATA_WIDTH-1){1'b0}}};
      else if (w_pexp[XE_W-1] || (w_pexp == '0))
         w_res = {r_sl, {(FLOAT_DATA_WIDTH-1){1'b0}}};
      else if (w_pexp >= {2'b00, EXP_MAX})
         w_res = {r_sl, EXP_MAX, {MANT_WIDTH{1'b0}}};
      else
         w_res = {r_sl, w_pexp[EXP_WIDTH-1:0], w_frac};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         result     <= '0;
         done       <= 1'b0;
         working    <= 1'b0;
         r_a        <= '0;
         r_b        <= '0;
         r_sl       <= 1'b0;
         r_ss       <= 1'b0;
         r_el       <= '0;
         r_es       <= '0;
         r_ml       <= '0;
         r_ms       <= '0;
         r_fl       <= '0;
         r_fs       <= '0;
         r_sum      <= '0;
         r_norm     <= '0;
         r_exp      <= '0;
         r_nan      <= 1'b0;
         r_inf      <= 1'b0;
         r_inf_sign <= 1'b0;
         r_zero     <= 1'b0;
      end else if (clk_en) begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a     <= to_add_one;
                  r_b     <= to_add_two;
                  working <= 1'b1;
                  r_state <= S_UNPACK;
               end
            end
            S_UNPACK: begin
               r_nan      <= w_nan_a | w_nan_b | (w_inf_a & w_inf_b & (w_sa != w_sb));
               r_inf      <= w_inf_a | w_inf_b;
               r_inf_sign <= w_inf_a ? w_sa : w_sb;
               r_sl       <= w_a_ge_b ? w_sa : w_sb;
               r_ss       <= w_a_ge_b ? w_sb : w_sa;
               r_el       <= w_a_ge_b ? w_ea : w_eb;
               r_es       <= w_a_ge_b ? w_eb : w_ea;
               r_ml       <= w_a_ge_b ? w_ma : w_mb;
               r_ms       <= w_a_ge_b ? w_mb : w_ma;
               r_state    <= S_ALIGN;
            end
            S_ALIGN: begin
               r_fl    <= {r_ml, 3'b000};
               r_fs    <= w_fs;
               r_state <= S_ADD;
            end
            S_ADD: begin
               r_sum   <= w_sum;
               r_exp   <= {2'b00, r_el};
               r_state <= S_NORM;
            end
            S_NORM: begin
               r_norm  <= w_norm;
               r_exp   <= w_nexp;
               r_zero  <= (r_sum == '0);
               r_state <= S_PACK;
            end
            S_PACK: begin
               result  <= w_res;
               done    <= 1'b1;
               working <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_stage_4.sv
// Directed self-checking bench for stage_4: latency, specials, rounding,
// stall, asynchronous reset and back-to-back throughput.
module tb_stage_4;
   logic        clk;
   logic        rst;
   logic        clk_en;
   logic        start;
   logic [31:0] op_a, op_b;
   logic [31:0] result;
   logic        done;
   logic        working;

   int tests = 0;
   int fails = 0;

   stage_4 dut (
      .clk        (clk),
      .rst        (rst),
      .clk_en     (clk_en),
      .start      (start),
      .to_add_one (op_a),
      .to_add_two (op_b),
      .result     (result),
      .done       (done),
      .working    (working)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Launch one operation and wait (bounded) for done; returns edges after start edge.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output int cyc);
      @(negedge clk);
      start = 1'b1; op_a = a; op_b = b;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (done !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      r = result;
   endtask

   task automatic test_reset;
      #1;
      tests++;
      if (result !== 32'h0) begin fails++; $display("FAIL reset_result: got %h expected %h", result, 32'h0); end
      tests++;
      if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
      tests++;
      if (working !== 1'b0) begin fails++; $display("FAIL reset_working: got %b expected 0", working); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      @(negedge clk);
      start = 1'b1; op_a = 32'h3F80_0000; op_b = 32'h4000_0000;
      @(negedge clk);
      start = 1'b0;
      for (int n = 0; n <= 6; n++) begin
         tests++;
         if (done !== (n == 5)) begin
            fails++; $display("FAIL basic_done n=%0d: got %b expected %b", n, done, (n == 5));
         end
         tests++;
         if (working !== (n < 5)) begin
            fails++; $display("FAIL basic_working n=%0d: got %b expected %b", n, working, (n < 5));
         end
         if (n == 5) begin
            tests++;
            if (result !== 32'h4040_0000) begin
               fails++; $display("FAIL basic_result: got %h expected %h", result, 32'h4040_0000);
            end
         end
         if (n < 6) @(negedge clk);
      end
   endtask

   task automatic test_special;
      logic [31:0] va [6] = '{32'h3FC0_0000, 32'h7F80_0000, 32'h7F7F_FFFF,
                              32'h7FC0_1234, 32'hFF80_0000, 32'h0000_0000};
      logic [31:0] vb [6] = '{32'hBFC0_0000, 32'hFF80_0000, 32'h7F7F_FFFF,
                              32'h3F80_0000, 32'h4000_0000, 32'hC120_0000};
      logic [31:0] ve [6] = '{32'h0000_0000, 32'h7FC0_0000, 32'h7F80_0000,
                              32'h7FC0_0000, 32'hFF80_0000, 32'hC120_0000};
      logic [31:0] r;
      int cyc;
      for (int i = 0; i < 6; i++) begin
         run_op(va[i], vb[i], r, cyc);
         tests++;
         if (cyc !== 5) begin fails++; $display("FAIL special_latency[%0d]: got %0d expected 5", i, cyc); end
         tests++;
         if (r !== ve[i]) begin fails++; $display("FAIL special[%0d]: got %h expected %h", i, r, ve[i]); end
      end
   endtask

   task automatic test_rounding;
      logic [31:0] vb [3] = '{32'h3380_0000, 32'h3380_0001, 32'hB380_0000};
      logic [31:0] ve [3] = '{32'h3F80_0000, 32'h3F80_0001, 32'h3F7F_FFFF};
      logic [31:0] r;
      int cyc;
      for (int i = 0; i < 3; i++) begin
         run_op(32'h3F80_0000, vb[i], r, cyc);
         tests++;
         if (r !== ve[i] || cyc !== 5) begin
            fails++; $display("FAIL round[%0d]: got %h cyc %0d expected %h cyc 5", i, r, cyc, ve[i]);
         end
      end
   endtask

   task automatic test_stall;
      int first = -1;
      int nd = 0;
      logic [31:0] r = '0;
      run_op(32'h3F80_0000, 32'h4000_0000, r, first);
      first = -1;
      @(negedge clk);
      start = 1'b1; op_a = 32'h3FC0_0000; op_b = 32'h4020_0000;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      clk_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         tests++;
         if (working !== 1'b1 || done !== 1'b0 || result !== 32'h4040_0000) begin
            fails++;
            $display("FAIL stall_frozen[%0d]: got w=%b d=%b r=%h expected w=1 d=0 r=%h",
                     k, working, done, result, 32'h4040_0000);
         end
      end
      clk_en = 1'b1;
      for (int n = 5; n <= 20; n++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            nd++;
            if (first < 0) begin first = n; r = result; end
         end
         if (n == 5) begin start = 1'b1; op_a = 32'h3F80_0000; op_b = 32'h3F80_0000; end
         if (n == 6) start = 1'b0;
      end
      tests++;
      if (first !== 8) begin fails++; $display("FAIL stall_latency: got %0d expected 8", first); end
      tests++;
      if (nd !== 1) begin fails++; $display("FAIL stall_done_count: got %0d expected 1", nd); end
      tests++;
      if (r !== 32'h4080_0000) begin fails++; $display("FAIL stall_result: got %h expected %h", r, 32'h4080_0000); end
   endtask

   task automatic test_reset_mid;
      logic [31:0] r;
      int cyc;
      int nd = 0;
      @(negedge clk);
      start = 1'b1; op_a = 32'h3F80_0000; op_b = 32'h4000_0000;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      tests++;
      if (result !== 32'h0 || done !== 1'b0 || working !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid: got r=%h d=%b w=%b expected r=0 d=0 w=0", result, done, working);
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (done === 1'b1) nd++;
      end
      tests++;
      if (nd !== 0) begin fails++; $display("FAIL reset_no_done: got %0d expected 0", nd); end
      run_op(32'h40A0_0000, 32'hC040_0000, r, cyc);
      tests++;
      if (r !== 32'h4000_0000 || cyc !== 5) begin
         fails++; $display("FAIL reset_fresh: got %h cyc %0d expected %h cyc 5", r, cyc, 32'h4000_0000);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] va [4] = '{32'h3FC0_0000, 32'h4120_0000, 32'h3F40_0000, 32'h42C8_0000};
      logic [31:0] vb [4] = '{32'h4020_0000, 32'hC080_0000, 32'h3F00_0000, 32'h3E80_0000};
      logic [31:0] ve [4] = '{32'h4080_0000, 32'h40C0_0000, 32'h3FA0_0000, 32'h42C8_8000};
      int cyc;
      @(negedge clk);
      start = 1'b1; op_a = va[0]; op_b = vb[0];
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start = 1'b0;
         cyc = 0;
         while (done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
         end
         tests++;
         if (cyc !== 5) begin fails++; $display("FAIL b2b_spacing[%0d]: got %0d expected 5", i, cyc); end
         tests++;
         if (result !== ve[i]) begin fails++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, result, ve[i]); end
         if (i < 3) begin start = 1'b1; op_a = va[i+1]; op_b = vb[i+1]; end
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0; clk_en = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
      test_reset();
      test_basic();
      test_special();
      test_rounding();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
